// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a bank of level-sensitive latches: turns a valid/ready request
// into setup / one-hot enable pulse / hold timing on a shared data bus.
module latch_bank_wr_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned DW           = 8,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  output logic [DW-1:0]    lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy,
  output logic             err_addr
);

  localparam int unsigned CW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned AW1 = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_W  = AW1'(DEPTH);

  if (PULSE_CYCLES == 0) begin : g_bad_pulse
    $error("latch_bank_wr_ctrl: PULSE_CYCLES must be >= 1");
  end
  if (DEPTH < 2 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("latch_bank_wr_ctrl: DEPTH must be in 2..2**AW");
  end

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    lat_d_d;
  logic [DEPTH-1:0] lat_en_d;
  logic             ready_d;
  logic             err_d;

  // State and registered outputs; async reset drops the enable without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lat_d    <= lat_d_d;
      lat_en   <= lat_en_d;
      wr_ready <= ready_d;
      busy     <= ~ready_d;
      err_addr <= err_d;
    end
  end

  // Next state and next output values; lat_d only reloads on the accept edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d;
    lat_en_d = '0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (wr_valid && wr_ready) begin
          addr_d  = wr_addr;
          lat_d_d = wr_data;
          err_d   = ({1'b0, wr_addr} >= DEPTH_W);
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // err_addr is high exactly during SETUP of an out-of-range request
        if (err_addr) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          state_d  = PULSE;
          cnt_d    = '0;
          lat_en_d = DEPTH'(1) << addr_q;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          lat_en_d = lat_en;
        end
      end
      HOLD: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed bench for latch_bank_wr_ctrl: a cycle table on an 8-entry/2-cycle instance,
// plus hand sequences for async reset, out-of-range address and other pulse widths.
module tb_latch_bank_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       v0, v1, v2;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  logic       r0, b0, x0;
  logic [7:0] d0, e0;
  logic       r1, b1, x1;
  logic [7:0] d1;
  logic [5:0] e1;
  logic       r2, b2, x2;
  logic [7:0] d2, e2;

  int checks = 0;
  int errors = 0;

  latch_bank_wr_ctrl #(.DEPTH(8), .AW(3), .DW(8), .PULSE_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v0), .wr_ready(r0), .wr_addr(wr_addr),
    .wr_data(wr_data), .lat_d(d0), .lat_en(e0), .busy(b0), .err_addr(x0));

  latch_bank_wr_ctrl #(.DEPTH(6), .AW(3), .DW(8), .PULSE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v1), .wr_ready(r1), .wr_addr(wr_addr),
    .wr_data(wr_data), .lat_d(d1), .lat_en(e1), .busy(b1), .err_addr(x1));

  latch_bank_wr_ctrl #(.DEPTH(8), .AW(3), .DW(8), .PULSE_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v2), .wr_ready(r2), .wr_addr(wr_addr),
    .wr_data(wr_data), .lat_d(d2), .lat_en(e2), .busy(b2), .err_addr(x2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic [7:0] d;
    logic [7:0] en;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic v, input logic [2:0] a,
                              input logic [7:0] dt, input logic rdy, input logic [7:0] d,
                              input logic [7:0] en);
    vec_t t;
    t.rst_n = rn; t.valid = v; t.addr = a; t.data = dt;
    t.ready = rdy; t.busy = ~rdy; t.d = d; t.en = en; t.err = 1'b0;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; wr_addr = '0; wr_data = '0;

    // inputs applied before an edge, expected outputs of u0 just after it
    vecs.push_back(mk(0, 0, 3'd0, 8'h00, 1, 8'h00, 8'h00)); // reset
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 1, 8'h00, 8'h00)); // idle
    vecs.push_back(mk(1, 1, 3'd3, 8'hA5, 0, 8'hA5, 8'h00)); // accept -> SETUP
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'hA5, 8'h08)); // PULSE 1
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'hA5, 8'h08)); // PULSE 2
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'hA5, 8'h00)); // HOLD
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 1, 8'hA5, 8'h00)); // IDLE, lat_d kept
    vecs.push_back(mk(1, 1, 3'd0, 8'h11, 0, 8'h11, 8'h00)); // back-to-back #1
    vecs.push_back(mk(1, 1, 3'd7, 8'h22, 0, 8'h11, 8'h01));
    vecs.push_back(mk(1, 1, 3'd7, 8'h22, 0, 8'h11, 8'h01));
    vecs.push_back(mk(1, 1, 3'd7, 8'h22, 0, 8'h11, 8'h00));
    vecs.push_back(mk(1, 1, 3'd7, 8'h22, 1, 8'h11, 8'h00)); // IDLE, valid still high
    vecs.push_back(mk(1, 1, 3'd7, 8'h22, 0, 8'h22, 8'h00)); // accept #2
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'h22, 8'h80));
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'h22, 8'h80));
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'h22, 8'h00));
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 1, 8'h22, 8'h00));
    vecs.push_back(mk(1, 1, 3'd2, 8'h33, 0, 8'h33, 8'h00)); // busy-time requests ignored
    vecs.push_back(mk(1, 1, 3'd5, 8'h44, 0, 8'h33, 8'h04));
    vecs.push_back(mk(1, 1, 3'd6, 8'h55, 0, 8'h33, 8'h04));
    vecs.push_back(mk(1, 1, 3'd1, 8'h66, 0, 8'h33, 8'h00));
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 1, 8'h33, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; v0 = vecs[i].valid;
      wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d {rdy,busy,d,en,err}", i),
            32'({r0, b0, d0, e0, x0}),
            32'({vecs[i].ready, vecs[i].busy, vecs[i].d, vecs[i].en, vecs[i].err}));
    end

    // reset during the first enable cycle clears lat_en before the next edge
    v0 = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
    tick();
    check("rst_mid setup lat_d", 32'(d0), 32'h77);
    v0 = 1'b0;
    tick();
    check("rst_mid pulse lat_en", 32'(e0), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid async lat_en", 32'(e0), 32'h00);
    check("rst_mid async ready/busy", 32'({r0, b0}), 32'b10);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_mid after release", 32'({r0, b0, d0, e0, x0}), 32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));

    // DEPTH=6, PULSE_CYCLES=1: out-of-range address then a width-1 pulse
    v1 = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
    tick();
    check("oor setup {err,en,rdy}", 32'({x1, e1, r1}), 32'({1'b1, 6'h00, 1'b0}));
    check("oor lat_d", 32'(d1), 32'hFF);
    v1 = 1'b0;
    tick();
    check("oor turnaround {err,en,rdy,busy}", 32'({x1, e1, r1, b1}), 32'({1'b0, 6'h00, 1'b1, 1'b0}));
    v1 = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    tick();
    check("pc1 setup {err,en,d}", 32'({x1, e1, d1}), 32'({1'b0, 6'h00, 8'h3C}));
    v1 = 1'b0;
    tick();
    check("pc1 pulse lat_en", 32'(e1), 32'h20);
    tick();
    check("pc1 hold {en,rdy,d}", 32'({e1, r1, d1}), 32'({6'h00, 1'b0, 8'h3C}));
    tick();
    check("pc1 idle ready", 32'({r1, b1}), 32'b10);

    // PULSE_CYCLES=4: enable high exactly four cycles
    v2 = 1'b1; wr_addr = 3'd6; wr_data = 8'hC3;
    tick();
    check("pc4 setup {en,d}", 32'({e2, d2}), 32'({8'h00, 8'hC3}));
    v2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("pc4 pulse%0d lat_en", k), 32'({e2, x2}), 32'({8'h40, 1'b0}));
    end
    tick();
    check("pc4 hold {en,rdy,d}", 32'({e2, r2, d2}), 32'({8'h00, 1'b0, 8'hC3}));
    tick();
    check("pc4 idle ready", 32'({r2, b2}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
